ovl_multi_no_overflow: RTL and testbench
========================================

Name: ovl_multi_no_overflow

Overview:
- Parametrised, multi-channel successor to the single-bit no-overflow checker used in the ivl_uvm OVL test suite.
- Monitors N_CH independent WIDTH-bit counters or expressions for overflow, underflow, or both, against configurable MIN/MAX bounds.
- Reports per-channel fire pulses, sticky status, a saturating failure count, and the index of the first failing channel.
- Instantiated inside test benches alongside the clock generator; it is non-intrusive and passive.

Parameters:
- N_CH, 4, number of monitored channels (1..32)
- WIDTH, 8, bits per channel expression
- MIN, 0, lower bound (unsigned, MIN < MAX)
- MAX, 2**WIDTH-1, upper bound (unsigned)
- MODE, 0, 0 = overflow check, 1 = underflow check, 2 = both
- CNT_W, 8, width of the failure counter

Ports:
- clock  input  1  checker clock, rising edge
- reset  input  1  asynchronous, active-high reset
- enable  input  1  global check enable
- clear  input  1  synchronous clear of sticky/count/first-fail state
- test_expr  input  N_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- fire  output  N_CH  per-channel one-cycle violation pulse
- fire_sticky  output  N_CH  per-channel latched violation
- fail_count  output  CNT_W  saturating count of cycles with any fire
- first_fail_valid  output  1  a first failure has been captured
- first_fail_ch  output  $clog2(N_CH) (min 1)  lowest channel index of the first failing cycle

Behaviour:
- Reset (async assert, released synchronously to clock):
  - All outputs are 0.
  - Every channel state is IDLE.
- Per-channel FSM, advanced on each rising clock edge while enable=1. v = the sampled channel value.
  - IDLE: v==MAX and MODE!=1 -> AT_MAX; v==MIN and MODE!=0 -> AT_MIN; else stay IDLE.
  - AT_MAX:
    - Violation (overflow) if v<=MIN or v>MAX.
    - Otherwise the next state is re-evaluated from v using the IDLE rules.
  - AT_MIN:
    - Violation (underflow) if v<MIN or v>=MAX.
    - Otherwise the next state is re-evaluated from v using the IDLE rules.
  - After a violation, the next state is also re-evaluated from v using the IDLE rules.
- fire[c]:
  - Registered; asserts for exactly one cycle.
  - Rises in the cycle after the edge that sampled the violating v.
- enable=0:
  - All channels are forced to IDLE.
  - fire is 0 on the next cycle.
  - Sticky, count and first-fail state are held.
  - Re-enabling starts fresh; there is no stale arming.
- fire_sticky[c]: set by fire[c]; held until clear or reset.
- fail_count:
  - Increments by 1 per cycle in which any fire bit is set, regardless of how many bits are set.
  - Saturates at 2**CNT_W-1 and does not wrap.
- first_fail_ch / first_fail_valid:
  - Captured on the first cycle with any fire while first_fail_valid=0.
  - first_fail_ch = lowest set fire index.
  - Frozen until clear.
- clear, applied on a clock edge:
  - Zeroes fire_sticky, fail_count and first_fail_valid/ch.
  - If fire is asserted in the same cycle, that fire's updates are applied after the clear: sticky=fire, count=1, first-fail captured.
  - clear does not alter channel FSMs or fire.
- Simultaneous events: each channel is evaluated independently; multiple fire bits may be set in one cycle.
- Reset asserted mid-operation clears everything immediately, including in-flight AT_MAX/AT_MIN arming.
- With MODE=2 and MIN==MAX-1, a channel alternates between AT_MAX and AT_MIN. Both checks apply in their respective states.

Optional Feature:
- Macro: OVL_MULTI_NO_OVERFLOW_XCHECK_EN
- Defined:
  - Any X/Z bit in a channel's sampled value while enable=1 and reset=0 forces fire[c]=1 on the next cycle. This counts as a violation (sticky, count and first-fail all update).
  - That channel returns to IDLE.
  - Simulation only; implemented with case-equality on the sampled value.
- Undefined:
  - No X/Z detection.
  - X values propagate through the range compares with no guaranteed fire.

Test Plan (N_CH=2, WIDTH=4, MIN=0, MAX=15, CNT_W=2 unless stated):
- Reset held 5 clocks with ch0 = 15 then 0 -> all outputs remain 0. After release, ch0 goes 14, 15, 3 -> no fire, count stays 0.
- Overflow wrap: ch0 goes 15 then 0 -> fire=2'b01 one cycle after the 0 is sampled; fire_sticky=01; fail_count=1; first_fail_ch=0.
- Simultaneous: both channels go 15 then 0 in the same cycles -> fire=2'b11; count increments by 1; first_fail_ch=0.
- Saturation and clear:
  - Four overflow events on ch1 -> fail_count=3 (saturated).
  - Pulse clear together with a fifth event -> next cycle fail_count=1, sticky=10, first_fail_ch=1.
- MODE=1, MIN=2, MAX=9: ch0 goes 2 then 1 -> underflow fire; ch0 goes 2 then 3 -> no fire.
- Enable gating: ch0 = 15, enable=0 for 1 clock, then enable=1 with ch0 = 0 -> no fire. Repeating with enable held high fires.

Source files
------------

// File: rtl/ovl_multi_no_overflow.sv
// rtl/ovl_multi_no_overflow.sv - multi-channel overflow/underflow checker with sticky status and first-fail capture
// Optional X/Z detection on sampled channel values under OVL_MULTI_NO_OVERFLOW_XCHECK_EN.
module ovl_multi_no_overflow #(
    parameter int               N_CH  = 4,
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MIN   = '0,
    parameter logic [WIDTH-1:0] MAX   = '1,
    parameter int               MODE  = 0,
    parameter int               CNT_W = 8,
    localparam int              CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [N_CH*WIDTH-1:0] test_expr,
    output logic [N_CH-1:0]       fire,
    output logic [N_CH-1:0]       fire_sticky,
    output logic [CNT_W-1:0]      fail_count,
    output logic                  first_fail_valid,
    output logic [CH_W-1:0]       first_fail_ch
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_AT_MAX = 2'd1,
        ST_AT_MIN = 2'd2
    } state_t;

    state_t            state_q [N_CH];
    state_t            state_d [N_CH];
    logic [N_CH-1:0]   fire_q, fire_d;
    logic [N_CH-1:0]   sticky_q, sticky_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ffv_q, ffv_d;
    logic [CH_W-1:0]   ffc_q, ffc_d;
    logic [CH_W-1:0]   low_idx;
    logic [WIDTH-1:0]  v;
    logic              viol;

    // Unsigned a < b via the borrow bit, so bounds at 0 or all-ones stay well-formed.
    function automatic logic lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[WIDTH];
    endfunction

    function automatic state_t arm(input logic [WIDTH-1:0] val);
        state_t s;
        s = ST_IDLE;
        if (val == MAX && MODE != 1)
            s = ST_AT_MAX;
        else if (val == MIN && MODE != 0)
            s = ST_AT_MIN;
        return s;
    endfunction

    always_comb begin
        fire_d = '0;
        v      = '0;
        viol   = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            state_d[c] = ST_IDLE;
            v          = test_expr[c*WIDTH +: WIDTH];
            viol       = 1'b0;
            if (enable) begin
                case (state_q[c])
                    ST_AT_MAX: viol = !lt(MIN, v) || lt(MAX, v);
                    ST_AT_MIN: viol = lt(v, MIN) || !lt(v, MAX);
                    default:   viol = 1'b0;
                endcase
                fire_d[c]  = viol;
                state_d[c] = arm(v);
`ifdef OVL_MULTI_NO_OVERFLOW_XCHECK_EN
                if ((^v) === 1'bx) begin
                    fire_d[c]  = 1'b1;
                    state_d[c] = ST_IDLE;
                end
`endif
            end
        end
    end

    always_comb begin
        low_idx = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (fire_q[c])
                low_idx = CH_W'(c);
        end
    end

    // Clear is applied first so a fire in the same cycle lands on the cleared state.
    always_comb begin
        sticky_d = clear ? '0 : sticky_q;
        count_d  = clear ? '0 : count_q;
        ffv_d    = clear ? 1'b0 : ffv_q;
        ffc_d    = clear ? '0 : ffc_q;
        if (|fire_q) begin
            sticky_d = sticky_d | fire_q;
            if (count_d != {CNT_W{1'b1}})
                count_d = count_d + CNT_W'(1);
            if (!ffv_d) begin
                ffv_d = 1'b1;
                ffc_d = low_idx;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < N_CH; c++)
                state_q[c] <= ST_IDLE;
            fire_q   <= '0;
            sticky_q <= '0;
            count_q  <= '0;
            ffv_q    <= 1'b0;
            ffc_q    <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++)
                state_q[c] <= state_d[c];
            fire_q   <= fire_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
            ffv_q    <= ffv_d;
            ffc_q    <= ffc_d;
        end
    end

    assign fire             = fire_q;
    assign fire_sticky      = sticky_q;
    assign fail_count       = count_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_ch    = ffc_q;

endmodule

// File: tb/tb_ovl_multi_no_overflow.sv
// tb/tb_ovl_multi_no_overflow.sv - self-checking bench for ovl_multi_no_overflow against a previous-sample reference model
module tb_ovl_multi_no_overflow;

    localparam int NI = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       clear = 1'b0;
    logic [7:0] tx = 8'h0F;

    logic [1:0] f0, s0, c0, f1, s1, c1, f2, s2, c2;
    logic       v0, h0, v1, h1, v2, h2;

    int n_chk = 0;
    int n_pass = 0;

    // Reference: a channel is armed when the previous enabled sample sat on a bound.
    int md [NI] = '{0, 1, 2};
    int mn [NI] = '{0, 2, 3};
    int mx [NI] = '{15, 9, 4};
    int prev [NI][2];
    bit pv [NI][2];
    bit [1:0] mfire [NI];
    bit [1:0] mst [NI];
    int mcnt [NI];
    bit mval [NI];
    int mch [NI];

    always #5 clock = ~clock;

    ovl_multi_no_overflow #(.N_CH(2), .WIDTH(4), .MIN(4'd0), .MAX(4'd15), .MODE(0), .CNT_W(2)) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .test_expr(tx),
        .fire(f0), .fire_sticky(s0), .fail_count(c0), .first_fail_valid(v0), .first_fail_ch(h0));

    ovl_multi_no_overflow #(.N_CH(2), .WIDTH(4), .MIN(4'd2), .MAX(4'd9), .MODE(1), .CNT_W(2)) dut_u (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .test_expr(tx),
        .fire(f1), .fire_sticky(s1), .fail_count(c1), .first_fail_valid(v1), .first_fail_ch(h1));

    ovl_multi_no_overflow #(.N_CH(2), .WIDTH(4), .MIN(4'd3), .MAX(4'd4), .MODE(2), .CNT_W(2)) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .test_expr(tx),
        .fire(f2), .fire_sticky(s2), .fail_count(c2), .first_fail_valid(v2), .first_fail_ch(h2));

    function automatic bit violates(int i, int p, int v);
        bit at_max, at_min;
        at_max = (md[i] != 1) && (p == mx[i]);
        at_min = (md[i] != 0) && (p == mn[i]) && !at_max;
        return (at_max && (v <= mn[i] || v > mx[i])) || (at_min && (v < mn[i] || v >= mx[i]));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mfire[i] = '0; mst[i] = '0; mcnt[i] = 0; mval[i] = 0; mch[i] = 0;
            for (int c = 0; c < 2; c++) begin
                pv[i][c] = 0; prev[i][c] = 0;
            end
        end
    endtask

    task automatic model_edge();
        bit [1:0] nf;
        int val;
        if (reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NI; i++) begin
            if (clear) begin
                mst[i] = '0; mcnt[i] = 0; mval[i] = 0; mch[i] = 0;
            end
            if (mfire[i] != 0) begin
                mst[i] = mst[i] | mfire[i];
                if (mcnt[i] < 3) mcnt[i] = mcnt[i] + 1;
                if (!mval[i]) begin
                    mval[i] = 1;
                    mch[i] = mfire[i][0] ? 0 : 1;
                end
            end
            for (int c = 0; c < 2; c++) begin
                val = int'(tx[c*4 +: 4]);
                nf[c] = enable && pv[i][c] && violates(i, prev[i][c], val);
                pv[i][c] = enable;
                prev[i][c] = val;
            end
            mfire[i] = nf;
        end
    endtask

    function automatic logic [7:0] exp_vec(int i);
        logic [1:0] cnt;
        cnt = 2'(mcnt[i]);
        return {mfire[i], mst[i], cnt, mval[i], mch[i] != 0};
    endfunction

    function automatic logic [7:0] act_vec(int i);
        case (i)
            0:       return {f0, s0, c0, v0, h0};
            1:       return {f1, s1, c1, v1, h1};
            default: return {f2, s2, c2, v2, h2};
        endcase
    endfunction

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 8; k++) begin
            if (k == 5) reset = 1'b0;
            tx = (k < 2) ? 8'h0F : (k < 5) ? 8'h00 : (k == 5) ? 8'h0E : (k == 6) ? 8'h0F : 8'h03;
            cycle();
            n_chk++;
            if (act_vec(0) !== 8'h00) $display("FAIL reset_quiet k=%0d got %h want 00", k, act_vec(0));
            else n_pass++;
        end
        cycle();
        for (int i = 0; i < NI; i++) begin
            n_chk++;
            if (act_vec(i) !== exp_vec(i)) $display("FAIL reset_model inst%0d got %h want %h", i, act_vec(i), exp_vec(i));
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        tx = 8'h0F; cycle();
        tx = 8'h00; cycle();
        n_chk++;
        if (f0 !== 2'b01) $display("FAIL ovf_fire got %b want 01", f0); else n_pass++;
        tx = 8'h03; cycle();
        n_chk++;
        if ({f0, s0, c0, v0, h0} !== 8'b00_01_01_1_0) $display("FAIL ovf_status got %b want 00010110", {f0, s0, c0, v0, h0});
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        clear = 1'b1; tx = 8'h33; cycle(); clear = 1'b0;
        tx = 8'hFF; cycle();
        tx = 8'h00; cycle();
        n_chk++;
        if (f0 !== 2'b11) $display("FAIL simul_fire got %b want 11", f0); else n_pass++;
        tx = 8'h33; cycle();
        n_chk++;
        if ({s0, c0, v0, h0} !== 6'b11_01_1_0) $display("FAIL simul_status got %b want 110110", {s0, c0, v0, h0});
        else n_pass++;
    endtask

    task automatic test_sat_clear();
        clear = 1'b1; tx = 8'h00; cycle(); clear = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tx = 8'hF0; cycle();
            tx = 8'h00; cycle();
        end
        cycle();
        n_chk++;
        if (c0 !== 2'd3) $display("FAIL sat_count got %0d want 3", c0); else n_pass++;
        tx = 8'hF0; cycle();
        tx = 8'h00; cycle();
        clear = 1'b1; cycle(); clear = 1'b0;
        n_chk++;
        if ({s0, c0, v0, h0} !== 6'b10_01_1_1) $display("FAIL clear_fire got %b want 100111", {s0, c0, v0, h0});
        else n_pass++;
    endtask

    task automatic test_underflow();
        clear = 1'b1; tx = 8'h00; cycle(); clear = 1'b0;
        tx = 8'h02; cycle();
        tx = 8'h01; cycle();
        n_chk++;
        if (f1 !== 2'b01) $display("FAIL udf_fire got %b want 01", f1); else n_pass++;
        tx = 8'h02; cycle();
        tx = 8'h03; cycle();
        n_chk++;
        if (f1 !== 2'b00) $display("FAIL udf_nofire got %b want 00", f1); else n_pass++;
    endtask

    task automatic test_enable();
        clear = 1'b1; tx = 8'h00; cycle(); clear = 1'b0;
        tx = 8'h0F; cycle();
        enable = 1'b0; cycle();
        enable = 1'b1; tx = 8'h00; cycle();
        n_chk++;
        if (f0 !== 2'b00) $display("FAIL enable_gate got %b want 00", f0); else n_pass++;
        tx = 8'h0F; cycle();
        tx = 8'h00; cycle();
        n_chk++;
        if (f0 !== 2'b01) $display("FAIL enable_fire got %b want 01", f0); else n_pass++;
        cycle();
        n_chk++;
        if (s0 !== 2'b01) $display("FAIL enable_sticky got %b want 01", s0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        tx = 8'h0F; cycle();
        reset = 1'b1;
        #1;
        model_reset();
        n_chk++;
        if (act_vec(0) !== 8'h00) $display("FAIL async_reset got %h want 00", act_vec(0)); else n_pass++;
        cycle();
        reset = 1'b0; tx = 8'h00; cycle();
        cycle();
        for (int i = 0; i < NI; i++) begin
            n_chk++;
            if (act_vec(i) !== exp_vec(i)) $display("FAIL reset_mid inst%0d got %h want %h", i, act_vec(i), exp_vec(i));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int pick [7] = '{0, 2, 3, 4, 9, 15, 1};
        for (int k = 0; k < 600; k++) begin
            reset  = ($urandom_range(0, 99) < 2);
            enable = ($urandom_range(0, 9) != 0);
            clear  = ($urandom_range(0, 19) == 0);
            for (int c = 0; c < 2; c++)
                tx[c*4 +: 4] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15))
                                                            : 4'(pick[$urandom_range(0, 6)]);
            cycle();
            for (int i = 0; i < NI; i++) begin
                n_chk++;
                if (act_vec(i) !== exp_vec(i))
                    $display("FAIL random k=%0d inst%0d got %h want %h", k, i, act_vec(i), exp_vec(i));
                else n_pass++;
            end
        end
        reset = 1'b0; clear = 1'b0; enable = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_overflow();
        test_simultaneous();
        test_sat_clear();
        test_underflow();
        test_enable();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
